switch_debounce: RTL
====================

Name: switch_debounce

Overview:
- Conditions the 16 raw board slide switches before they reach the one-hot card-index decoder in the card register path.
- Synchronises each switch into the clock domain and debounces the whole vector as a unit.
- Presents a stable 16-bit vector, a one-cycle change strobe, and a registered one-hot flag so downstream logic latches a card selection only on clean transitions.

Parameters:
- WIDTH, 16, number of switch inputs.
- DEBOUNCE_CYCLES, 500000, cycles the synchronised vector must hold unchanged before commit (10 ms at 50 MHz); legal range is ≥1.
- CNT_W, 20, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- switch_raw  input  WIDTH  unsynchronised switch pins.
- switch  output  WIDTH  debounced stable vector, feeds the card-index decoder.
- changed  output  1  one-cycle pulse in the cycle `switch` takes a new value.
- onehot  output  1  high while `switch` has exactly one bit set.

Behaviour:
- One clock (`clk`). Reset is asynchronous, active-low (`rst_n`).
- On reset, all state clears:
  - sync1, sync2, samp, switch = 0; cnt = 0.
  - changed = 0, onehot = 0, state = IDLE.
  - Reset asserted mid-SETTLE or COMMIT aborts the update; no pulse is issued.
- Synchroniser: every edge, sync1 <= switch_raw and sync2 <= sync1. No other logic reads switch_raw.
- FSM states: IDLE, SETTLE, COMMIT.
- IDLE:
  - If sync2 != switch: samp <= sync2, cnt <= 0, go to SETTLE.
  - Otherwise hold.
- SETTLE, in priority order:
  - (a) sync2 == switch: bounced back to the old value; go to IDLE, no pulse.
  - (b) sync2 != samp: samp <= sync2, cnt <= 0, stay in SETTLE (any bit change restarts the window).
  - (c) cnt == DEBOUNCE_CYCLES-1: go to COMMIT.
  - (d) otherwise cnt <= cnt+1.
- COMMIT:
  - switch <= samp.
  - onehot <= (samp has exactly one bit set); popcount or (samp!=0 && (samp&(samp-1))==0).
  - changed <= 1; go to IDLE.
  - sync2 is not examined here; a later difference is seen in the next IDLE cycle.
- changed is registered and high for exactly one cycle per commit; it coincides with the first cycle `switch` shows the new value. It is otherwise 0.
- Latency: raw vector stable from before edge k gives a new `switch` after edge k+DEBOUNCE_CYCLES+3. With DEBOUNCE_CYCLES=4, that is 8 edges counting edge k as the first.
- Bounces: any raw activity inside the window restarts the count. Several bits changing at staggered times produce a single commit of the final vector.
- Zero and multi-bit vectors are committed like any other (onehot=0); error flagging is the decoder's job.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Outputs are glitch-free registers; no combinational path from switch_raw to any output.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: rst_n=0 with raw=16'h0004 -> switch=0, changed=0, onehot=0. Release rst_n and hold raw -> switch=16'h0004 on the 8th edge after release, changed high exactly 1 cycle, onehot=1.
- Bounce settle: from switch=0, raw toggles 0/16'h0001 every 2 cycles for 12 cycles, then holds 16'h0001 -> exactly one changed pulse, switch=16'h0001 8 edges after the final toggle.
- Glitch reject: switch=16'h0001 stable, raw=16'h0002 for 3 cycles then back to 16'h0001 -> switch stays 16'h0001, changed never asserts.
- Multi-bit: raw=16'h0003 held -> switch=16'h0003, onehot=0, one changed pulse. Then raw=16'h8000 -> switch=16'h8000, onehot=1, second pulse.
- Staggered bits: raw=16'h0010 at edge t, raw=16'h0030 at edge t+2 -> single commit of 16'h0030 at edge t+2+8; 16'h0010 never appears on switch.
- Reset mid-settle: raw=16'h0100, assert rst_n=0 two cycles into SETTLE -> switch=0, changed=0. After release with raw held, commit 16'h0100 occurs 8 edges later.

Source files
------------

// File: rtl/switch_debounce.sv
// switch_debounce: synchronise and debounce the board slide switches as one vector
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   switch_raw unsynchronised switch pins
//   switch     debounced stable vector
//   changed    one-cycle pulse in the first cycle switch shows a new value
//   onehot     high while switch has exactly one bit set
module switch_debounce #(
  parameter int WIDTH = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch,
  output logic             changed,
  output logic             onehot
);
  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] sync1, sync2, samp, samp_nxt, switch_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic changed_nxt, onehot_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      samp <= '0;
      switch <= '0;
      cnt <= '0;
      changed <= 1'b0;
      onehot <= 1'b0;
      state <= IDLE;
    end else begin
      sync1 <= switch_raw;
      sync2 <= sync1;
      samp <= samp_nxt;
      switch <= switch_nxt;
      cnt <= cnt_nxt;
      changed <= changed_nxt;
      onehot <= onehot_nxt;
      state <= state_nxt;
    end
  always_comb begin
    state_nxt = state;
    samp_nxt = samp;
    cnt_nxt = cnt;
    switch_nxt = switch;
    changed_nxt = 1'b0;
    onehot_nxt = onehot;
    case (state)
      IDLE:
        if (sync2 != switch) begin
          samp_nxt = sync2;
          cnt_nxt = '0;
          state_nxt = SETTLE;
        end
      SETTLE:
        if (sync2 == switch) state_nxt = IDLE;
        else if (sync2 != samp) begin
          // any movement inside the window restarts it on the new vector
          samp_nxt = sync2;
          cnt_nxt = '0;
        end else if (cnt == LAST) state_nxt = COMMIT;
        else cnt_nxt = cnt + 1'b1;
      COMMIT: begin
        switch_nxt = samp;
        onehot_nxt = (samp != '0) && ((samp & (samp - WIDTH'(1))) == '0);
        changed_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
